// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
//
// Purpose:
//   Returns a customer's change through a coin hopper. An inactivity timer runs
//   after each coin insertion or item selection. Change is returned either on
//   request or when the timer expires. Dispensing is greedy: each coin is the
//   largest denomination (1000 / 500 / 100) that does not exceed the balance
//   still owed. Any remainder below 100 is reported as a residual when
//   dispensing finishes.
//
// Ports:
//   clk              rising-edge clock for all state
//   reset            synchronous, active-high; also forces every output to 0
//   i_activity       coin inserted / item selected; restarts the wait timer
//   i_trigger_return immediate change-return request (wins over i_activity)
//   i_balance        machine balance, latched on every entry to DISPENSE
//   i_hopper_ready   hopper accepts the offered coin this cycle
//   o_return_coin    one-hot coin offered: bit2=1000, bit1=500, bit0=100
//   o_coin_valid     o_return_coin is valid
//   o_busy           high in DISPENSE and DONE
//   o_done           one-cycle pulse when dispensing ends
//   o_residual       undispensable remainder (<100), non-zero only with o_done
//   o_wait_time      current wait timer value
// -----------------------------------------------------------------------------
module change_dispense_ctrl #(
    parameter int WAIT_CYCLES = 10,
    parameter int BAL_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_activity,
    input  logic             i_trigger_return,
    input  logic [BAL_W-1:0] i_balance,
    input  logic             i_hopper_ready,
    output logic [2:0]       o_return_coin,
    output logic             o_coin_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [BAL_W-1:0] o_residual,
    output logic [31:0]      o_wait_time
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [BAL_W-1:0] COIN_100  = BAL_W'(100);
    localparam logic [BAL_W-1:0] COIN_500  = BAL_W'(500);
    localparam logic [BAL_W-1:0] COIN_1000 = BAL_W'(1000);

    // Greedy choice: largest coin not exceeding the amount still owed.
    // Because a coin is only chosen when it fits, the later subtraction
    // can never underflow.
    function automatic logic [2:0] coin_sel(input logic [BAL_W-1:0] rem);
        if (rem >= COIN_1000)     coin_sel = 3'b100;
        else if (rem >= COIN_500) coin_sel = 3'b010;
        else if (rem >= COIN_100) coin_sel = 3'b001;
        else                      coin_sel = 3'b000;
    endfunction

    function automatic logic [BAL_W-1:0] coin_val(input logic [2:0] sel);
        case (sel)
            3'b100:  coin_val = COIN_1000;
            3'b010:  coin_val = COIN_500;
            3'b001:  coin_val = COIN_100;
            default: coin_val = '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [BAL_W-1:0] rem_q, rem_d;
    logic [31:0]      timer_q, timer_d;
    logic [2:0]       sel;
    logic             coin_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        sel     = coin_sel(rem_q);
        coin_ok = (rem_q >= COIN_100);

        case (state_q)
            S_IDLE: begin
                if (i_trigger_return) begin
                    state_d = S_DISPENSE;
                    rem_d   = i_balance;
                    timer_d = '0;
                end else if (i_activity) begin
                    state_d = S_WAIT;
                    timer_d = 32'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (i_trigger_return) begin
                    state_d = S_DISPENSE;
                    rem_d   = i_balance;
                    timer_d = '0;
                end else if (i_activity) begin
                    timer_d = 32'(WAIT_CYCLES);
                end else if (timer_q <= 32'd1) begin
                    // Timer expires on this edge: hand over to dispensing.
                    state_d = S_DISPENSE;
                    rem_d   = i_balance;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_DISPENSE: begin
                if (!coin_ok) begin
                    state_d = S_DONE;
                end else if (i_hopper_ready) begin
                    rem_d = rem_q - coin_val(sel);
                    // Finish straight after the last coin that fits so that
                    // o_done follows the final transfer without a gap cycle.
                    if (rem_d < COIN_100) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are gated by reset so nothing is offered (and then silently
    // lost to the reset) while reset is held.
    always_comb begin
        o_coin_valid  = !reset && (state_q == S_DISPENSE) && coin_ok;
        o_return_coin = o_coin_valid ? sel : 3'b000;
        o_busy        = !reset && ((state_q == S_DISPENSE) || (state_q == S_DONE));
        o_done        = !reset && (state_q == S_DONE);
        o_residual    = o_done ? rem_q : '0;
        o_wait_time   = reset ? 32'd0 : timer_q;
    end

endmodule

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 10, giving the inactivity timeout in clock cycles before change is returned automatically.
REQ-002 The block SHALL have parameter BAL_W, default 16, giving the width of the balance in currency units.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_activity  input  1  pulse meaning a coin was inserted or an item was selected; it restarts the wait timer.
REQ-006 The block SHALL have port i_trigger_return  input  1  request to return change immediately.
REQ-007 The block SHALL have port i_balance  input  BAL_W  current balance held by the machine; sampled only on entry to DISPENSE.
REQ-008 The block SHALL have port i_hopper_ready  input  1  coin hopper can accept a coin this cycle.
REQ-009 The block SHALL have port o_return_coin  output  3  one-hot coin being dispensed: bit2=1000, bit1=500, bit0=100.
REQ-010 The block SHALL have port o_coin_valid  output  1  o_return_coin is valid.
REQ-011 The block SHALL have port o_busy  output  1  high while in DISPENSE or DONE.
REQ-012 The block SHALL have port o_done  output  1  one-cycle pulse when dispensing ends.
REQ-013 The block SHALL have port o_residual  output  BAL_W  undispensable remainder (<100), valid while o_done=1.
REQ-014 The block SHALL have port o_wait_time  output  32  current value of the wait timer.

Function
REQ-015 The block SHALL have states IDLE, WAIT, DISPENSE and DONE.
REQ-016 IDLE: i_activity=1 SHALL go to WAIT and load the timer with WAIT_CYCLES; i_trigger_return=1 SHALL go to DISPENSE; i_trigger_return SHALL win over i_activity.
REQ-017 WAIT: i_trigger_return=1 SHALL go to DISPENSE; otherwise i_activity=1 SHALL reload WAIT_CYCLES; otherwise the timer SHALL decrement by 1.
REQ-018 WAIT: at the edge where the timer is 1 and no trigger or activity is present, the timer SHALL become 0 and the state DISPENSE.
REQ-019 On every transition into DISPENSE, the remaining register SHALL latch i_balance and the timer SHALL clear to 0.
REQ-020 DISPENSE: o_coin_valid SHALL be 1 whenever remaining >= 100.
REQ-021 DISPENSE: o_return_coin SHALL select the largest coin <= remaining (greedy); it SHALL be combinational from the registered remaining.
REQ-022 A coin SHALL transfer only in a cycle with o_coin_valid and i_hopper_ready both 1; remaining SHALL then decrease by that coin value at the edge.
REQ-023 While i_hopper_ready=0, o_coin_valid and o_return_coin SHALL hold steady and remaining SHALL not change.
REQ-024 When remaining < 100 in DISPENSE, o_coin_valid SHALL be 0 and the next state SHALL be DONE; a latched balance < 100 therefore dispenses zero coins.
REQ-025 DONE: o_done=1 and o_residual=remaining for exactly one cycle, then the state SHALL return to IDLE.
REQ-026 i_activity and i_trigger_return SHALL be ignored in DISPENSE and DONE.
REQ-027 Outside DISPENSE, o_coin_valid SHALL be 0 and o_return_coin SHALL be 3'b000.
REQ-028 Outside DONE, o_done SHALL be 0 and o_residual SHALL be 0.
REQ-029 Subtraction SHALL never underflow, since a coin is only selected if it is <= remaining.

Reset
REQ-030 When reset=1 at a rising edge, state SHALL go to IDLE and timer and remaining SHALL clear to 0; reset SHALL take priority over all other inputs.
REQ-031 While in reset, o_return_coin, o_coin_valid, o_busy, o_done, o_residual and o_wait_time SHALL all be 0.
REQ-032 Reset asserted mid-dispense SHALL abort with no further coin offered; the balance is not restored.

Verification
REQ-033 Balance 1600, ready=1, trigger at edge 0: the bench SHALL see coins 100b, 010b, 001b in cycles 1-3, o_done in cycle 4 with residual 0, then IDLE.
REQ-034 Timeout, balance 500: an i_activity pulse at edge 0 with no further input SHALL give o_wait_time 10..1 in cycles 1-10, DISPENSE at edge 10, and 010b offered in cycle 11.
REQ-035 Reload: i_activity pulses at edge 0 and edge 5 SHALL move DISPENSE entry to edge 15.
REQ-036 Back-pressure, balance 1100: with ready=0 for cycles 1-3, 100b SHALL be held valid and 001b transferred only after ready rises; o_done follows the transfer.
REQ-037 Balance 250: the bench SHALL see two 100-unit coins, then o_done with residual 50.
REQ-038 Balance 50: o_done SHALL come with residual 50 and no coin.
REQ-039 Reset mid-dispense: reset in cycle 2 of a balance-2000 dispense SHALL clear all outputs next cycle and give no further coins.
